dmem_arbiter: RTL
=================

# dmem_arbiter

Single-port data-memory arbiter and sequencer placed between the single-cycle CPU's data-memory port and a synchronous, one-cycle-latency block RAM. It shares the RAM with a secondary master (debug loader / display reader), inserts CPU stall cycles for reads and lost arbitration, and bounds aux starvation with a configurable counter. CPU traffic arrives already aligned, with byte enables.

## Interface
- ADDR_W, 32, address width of both masters and the RAM.
- DATA_W, 32, data width; byte enables are DATA_W/8 wide.
- STARVE_MAX, 4, max consecutive cycles a requesting aux may lose to the CPU; 0 = aux always wins.

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU access valid this cycle (load or store)
- cpu_we  in  DATA_W/8  CPU byte write enables; all-zero = read
- cpu_addr  in  ADDR_W  CPU aligned address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_rdata  out  DATA_W  CPU load data, valid when in CPU_RESP
- cpu_stall  out  1  freeze CPU PC/regfile this cycle
- aux_req  in  1  aux access request, held until aux_gnt
- aux_we  in  DATA_W/8  aux byte write enables; all-zero = read
- aux_addr  in  ADDR_W  aux address
- aux_wdata  in  DATA_W  aux store data
- aux_gnt  out  1  aux access issued this cycle
- aux_rvalid  out  1  aux_rdata valid (cycle after granted aux read)
- aux_rdata  out  DATA_W  aux read data
- mem_en  out  1  RAM port enable
- mem_we  out  DATA_W/8  RAM byte write enables
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, one cycle after mem_en with mem_we==0

## Operation
- States: IDLE, CPU_RESP.
- IDLE candidates: CPU (cpu_req), aux (aux_req). CPU_RESP candidate: aux only (CPU access completing).
- Winner: CPU, unless starve_cnt == STARVE_MAX and aux_req, then aux. Single candidate always wins.
- Winner drives mem_en=1, mem_we/addr/wdata from its port; no winner: mem_en=0, mem_we=0.
- CPU write granted: completes this cycle, cpu_stall=0, stay IDLE.
- CPU read granted: cpu_stall=1, next state CPU_RESP.
- CPU request not granted (aux wins in IDLE): cpu_stall=1, stay IDLE, CPU retries unchanged.
- CPU_RESP: cpu_rdata=mem_rdata, cpu_stall=0, next state IDLE regardless of aux grant.
- cpu_req=0: cpu_stall=0.
- aux_gnt combinational in grant cycle; aux_rvalid registered, high exactly one cycle after a granted aux read; aux_rdata=mem_rdata.
- starve_cnt, width $clog2(STARVE_MAX+1): +1 each cycle aux_req=1 and aux_gnt=0 (saturating at STARVE_MAX); cleared on aux_gnt or aux_req=0.
- No forwarding; same-address write/read ordering follows grant order.

## Timing
- Reset (rst=0 at edge): state IDLE, starve_cnt 0, aux_rvalid 0. While rst=0, combinational outputs forced: mem_en 0, mem_we 0, aux_gnt 0, cpu_stall 0; cpu_rdata/aux_rdata follow mem_rdata.
- Reset mid-read: pending CPU_RESP or aux_rvalid dropped; no response after release.
- CPU load latency: 2 cycles (1 stall); store 1 cycle when uncontended.
- Aux read: gnt cycle N, rvalid N+1; back-to-back aux grants allowed every cycle.
- Worst-case aux wait: STARVE_MAX+1 cycles after CPU-busy start.

## Configuration
- DMEM_ARBITER_PERF_EN defined: adds outputs perf_cpu_stall_cnt[31:0] (cycles cpu_stall=1) and perf_aux_gnt_cnt[31:0] (aux grants), wrapping, cleared by reset.
- Undefined: ports and counters absent; arbitration identical.

## Structure
- Package dmem_arb_pkg: state enum (IDLE, CPU_RESP), owner enum (OWN_NONE, OWN_CPU, OWN_AUX), default STARVE_MAX constant.
- Sub-module dmem_arb_perf: the two performance counters, instantiated only under DMEM_ARBITER_PERF_EN.

## Test plan
- CPU load addr 0x10, RAM holds 0xDEADBEEF -> cpu_stall 1 cycle, then cpu_rdata=0xDEADBEEF, stall 0.
- CPU store we=4'b0011 addr 0x20 data 0x1234 -> mem_we=4'b0011 same cycle, no stall; aux read 0x20 later returns low half 0x1234.
- CPU and aux request every cycle, STARVE_MAX=4 -> aux_gnt on 5th cycle, cpu_stall that cycle, counter back to 0.
- Aux read granted during CPU_RESP -> cpu_rdata correct, aux_rvalid next cycle with its data.
- rst low during CPU_RESP -> no aux_rvalid/stall after release, state IDLE, mem_en 0.
- With DMEM_ARBITER_PERF_EN: 3 stalls, 2 aux grants -> counters read 3 and 2.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// The top-level FSM and grant logic import this package.
package dmem_arb_pkg;

   // Arbiter FSM states.
   // CPU_RESP is the cycle in which a granted CPU load returns its data.
   typedef enum logic [0:0] {
      IDLE,
      CPU_RESP
   } arb_state_t;

   // Owner of the RAM port in the current cycle.
   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_CPU,
      OWN_AUX
   } owner_t;

   // Number of consecutive cycles a requesting aux master may lose to the CPU.
   localparam int DEFAULT_STARVE_MAX = 4;

endpackage

// File: rtl/dmem_arb_perf.sv
// Performance counters for the data-memory arbiter.
// The top instantiates this module only when DMEM_ARBITER_PERF_EN is defined.
// Both counters wrap at 2^32 and are cleared by the synchronous active-low reset.
module dmem_arb_perf (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_stall,
   input  logic        aux_gnt,
   output logic [31:0] perf_cpu_stall_cnt,
   output logic [31:0] perf_aux_gnt_cnt
);

   // Count CPU stall cycles and aux grants, with wrap-around.
   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_cpu_stall_cnt <= '0;
         perf_aux_gnt_cnt   <= '0;
      end else begin
         if (cpu_stall) begin
            perf_cpu_stall_cnt <= perf_cpu_stall_cnt + 32'd1;
         end
         if (aux_gnt) begin
            perf_aux_gnt_cnt <= perf_aux_gnt_cnt + 32'd1;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU data port and an auxiliary
// master, in front of a one-cycle-latency synchronous block RAM.
// The CPU normally wins arbitration. A requesting aux master that has lost
// STARVE_MAX cycles in a row wins the next contended cycle.
// Optional feature: define DMEM_ARBITER_PERF_EN to add the perf_* counter ports.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = DEFAULT_STARVE_MAX
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cpu_req,
   input  logic [DATA_W/8-1:0] cpu_we,
   input  logic [ADDR_W-1:0]   cpu_addr,
   input  logic [DATA_W-1:0]   cpu_wdata,
   output logic [DATA_W-1:0]   cpu_rdata,
   output logic                cpu_stall,
   input  logic                aux_req,
   input  logic [DATA_W/8-1:0] aux_we,
   input  logic [ADDR_W-1:0]   aux_addr,
   input  logic [DATA_W-1:0]   aux_wdata,
   output logic                aux_gnt,
   output logic                aux_rvalid,
   output logic [DATA_W-1:0]   aux_rdata,
   output logic                mem_en,
   output logic [DATA_W/8-1:0] mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
`ifdef DMEM_ARBITER_PERF_EN
   output logic [31:0]         perf_cpu_stall_cnt,
   output logic [31:0]         perf_aux_gnt_cnt,
`endif
   input  logic [DATA_W-1:0]   mem_rdata
);

   // A zero STARVE_MAX still needs a one-bit counter, which then stays at zero.
   localparam int                CNT_W        = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [CNT_W-1:0]  STARVE_LIMIT = CNT_W'(STARVE_MAX);

   arb_state_t       state;
   logic [CNT_W-1:0] starve_cnt;
   owner_t           owner;
   logic             cpu_cand;
   logic             aux_favoured;

   // Pick the port owner.
   // The CPU competes only from IDLE. Aux beats the CPU once it is starved.
   // Reset forces no owner.
   always_comb begin
      cpu_cand     = (state == IDLE) && cpu_req;
      aux_favoured = (starve_cnt == STARVE_LIMIT);
      owner        = OWN_NONE;
      if (!rst) begin
         owner = OWN_NONE;
      end else if (aux_req && (!cpu_cand || aux_favoured)) begin
         owner = OWN_AUX;
      end else if (cpu_cand) begin
         owner = OWN_CPU;
      end
   end

   // Steer the owner's request onto the RAM port.
   // The port stays idle when nobody owns it.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = '0;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      case (owner)
         OWN_CPU: begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
         end
         OWN_AUX: begin
            mem_en    = 1'b1;
            mem_we    = aux_we;
            mem_addr  = aux_addr;
            mem_wdata = aux_wdata;
         end
         default: begin
         end
      endcase
   end

   // Stall the CPU when its request lost, or when it won with a load that returns next cycle.
   // Aux sees its grant in the same cycle.
   always_comb begin
      aux_gnt   = (owner == OWN_AUX);
      cpu_stall = (cpu_cand && (owner == OWN_AUX)) ||
                  ((owner == OWN_CPU) && (cpu_we == '0));
   end

   // The RAM read data is shared by both masters.
   // Each master qualifies it with its own response timing.
   assign cpu_rdata = mem_rdata;
   assign aux_rdata = mem_rdata;

   // Sequence the FSM, the aux read-valid flag and the aux starvation counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         starve_cnt <= '0;
         aux_rvalid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if ((owner == OWN_CPU) && (cpu_we == '0)) begin
                  state <= CPU_RESP;
               end
            end
            CPU_RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
         aux_rvalid <= aux_gnt && (aux_we == '0);
         if (aux_req && !aux_gnt) begin
            if (starve_cnt != STARVE_LIMIT) begin
               starve_cnt <= starve_cnt + CNT_W'(1);
            end
         end else begin
            starve_cnt <= '0;
         end
      end
   end

`ifdef DMEM_ARBITER_PERF_EN
   // Optional stall and grant counters.
   dmem_arb_perf u_perf (
      .clk                (clk),
      .rst                (rst),
      .cpu_stall          (cpu_stall),
      .aux_gnt            (aux_gnt),
      .perf_cpu_stall_cnt (perf_cpu_stall_cnt),
      .perf_aux_gnt_cnt   (perf_aux_gnt_cnt)
   );
`endif

endmodule
